// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 valid/ready stream demultiplexer with a registered
// 1-entry slot per output, so no combinational path runs from s_data to m*_data.
// Each beat is routed to output 0 or output 1 according to s_sel.
//
// Optional feature: define DEMUX_CNT_EN to enable the per-output delivered-beat
// counters. When it is undefined, m0_cnt and m1_cnt are tied to 0. The port list
// is the same in both builds.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready   input handshake (s_ready is combinational)
//   s_sel             destination of the current beat: 0 -> m0, 1 -> m1
//   s_data            input payload
//   m0_valid/m0_ready output 0 handshake
//   m0_data           output 0 payload (registered)
//   m1_valid/m1_ready output 1 handshake
//   m1_data           output 1 payload (registered)
//   m0_cnt/m1_cnt     beats delivered per output (DEMUX_CNT_EN only, else 0)
module stream_demux #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [DATA_W-1:0] s_data,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic [CNT_W-1:0]  m0_cnt,
  output logic [CNT_W-1:0]  m1_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e       m0_state_q, m0_state_d;
  slot_state_e       m1_state_q, m1_state_d;
  logic [DATA_W-1:0] m0_data_q, m0_data_d;
  logic [DATA_W-1:0] m1_data_q, m1_data_d;
  logic              load0, load1, drain0, drain1;

  assign m0_valid = (m0_state_q == FULL);
  assign m1_valid = (m1_state_q == FULL);
  assign m0_data  = m0_data_q;
  assign m1_data  = m1_data_q;
  assign drain0   = m0_valid & m0_ready;
  assign drain1   = m1_valid & m1_ready;

  // Only the selected slot gates acceptance; a full, stalled slot blocks the stream.
  assign s_ready = rst_n & (s_sel ? (~m1_valid | m1_ready) : (~m0_valid | m0_ready));
  assign load0   = s_valid & s_ready & ~s_sel;
  assign load1   = s_valid & s_ready &  s_sel;

  // Slot next-state and payload load.
  always_comb begin
    m0_state_d = m0_state_q;
    m1_state_d = m1_state_q;
    m0_data_d  = m0_data_q;
    m1_data_d  = m1_data_q;

    case (m0_state_q)
      EMPTY:   if (load0) m0_state_d = FULL;
      FULL:    if (drain0 && !load0) m0_state_d = EMPTY;
      default: m0_state_d = EMPTY;
    endcase

    case (m1_state_q)
      EMPTY:   if (load1) m1_state_d = FULL;
      FULL:    if (drain1 && !load1) m1_state_d = EMPTY;
      default: m1_state_d = EMPTY;
    endcase

    if (load0) m0_data_d = s_data;
    if (load1) m1_data_d = s_data;
  end

  // Slot state and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_state_q <= EMPTY;
      m1_state_q <= EMPTY;
      m0_data_q  <= '0;
      m1_data_q  <= '0;
    end else begin
      m0_state_q <= m0_state_d;
      m1_state_q <= m1_state_d;
      m0_data_q  <= m0_data_d;
      m1_data_q  <= m1_data_d;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] m0_cnt_q, m0_cnt_d;
  logic [CNT_W-1:0] m1_cnt_q, m1_cnt_d;

  // Delivered-beat counters; they wrap naturally at 2^CNT_W.
  always_comb begin
    m0_cnt_d = m0_cnt_q;
    m1_cnt_d = m1_cnt_q;
    if (drain0) m0_cnt_d = m0_cnt_q + CNT_W'(1);
    if (drain1) m1_cnt_d = m1_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
    end else begin
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
    end
  end

  assign m0_cnt = m0_cnt_q;
  assign m1_cnt = m1_cnt_q;
`else
  assign m0_cnt = '0;
  assign m1_cnt = '0;
`endif

endmodule
